cv32e40p_tmr_fault_manager: RTL and testbench

//  Consumer end of the TMR voting path: takes per-replica mismatch flags from the result voters,

---
 rtl/cv32e40p_tmr_pkg.sv | 38 +++
 rtl/cv32e40p_tmr_sat_cnt.sv | 25 ++
 rtl/cv32e40p_tmr_fault_manager.sv | 219 +++++++++++++++++++++
 tb/tb_cv32e40p_tmr_fault_manager.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tmr_pkg.sv
// Shared TMR definitions: replica count, FSM state encoding and bit helpers.
// Imported by the fault manager, its counter sub-module and voter instantiation sites.
package cv32e40p_tmr_pkg;

    localparam int unsigned NUM_REPLICAS = 3;

    typedef logic [1:0] replica_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALT   = 2'd1,
        RESYNC = 2'd2,
        FATAL  = 2'd3
    } tmr_state_e;

    // One-hot replica select from an index.
    function automatic logic [NUM_REPLICAS-1:0] onehot(input replica_idx_t idx);
        logic [NUM_REPLICAS-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < NUM_REPLICAS; i++) begin
            if (idx == replica_idx_t'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Number of set bits in a replica vector.
    function automatic logic [1:0] count_ones(input logic [NUM_REPLICAS-1:0] vec);
        logic [1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_REPLICAS; i++) begin
            n = n + 2'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_sat_cnt.sv
// Saturating per-replica error counter.
// Ports: clk, rst_n (async active-low), inc (count up by one), clr (synchronous clear),
//        value (current count, holds at 2**CNT_W-1).
module cv32e40p_tmr_sat_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: classifies voter mismatch events, sequences halt/resync/resume recovery,
// keeps saturating per-replica error counts, retires replicas past a threshold and escalates
// to a sticky fatal state once majority voting is no longer possible.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fault_valid_i       voter outputs valid this cycle
//   mismatch_i[2:0]     per-replica mismatch flags
//   halt_ack_i          core pipeline halted
//   clear_i             clear counters and disabled flags (IDLE only, no concurrent event)
//   halt_req_o          request core halt
//   resync_o            copy voted state into the replica in resync_replica_o
//   resync_replica_o    one-hot replica being resynced
//   replica_disabled_o  sticky permanent-fault flags
//   fatal_o             uncorrectable fault, sticky until reset
//   err_cnt_o           per-replica error counts, replica k at [k*CNT_W +: CNT_W]
// Optional build macro CV32E40P_TMR_FAULT_LOG_EN adds last_fault_cycle_o / last_fault_mask_o,
// a timestamp of the most recent raw mismatch from a free-running 32-bit cycle counter.
module cv32e40p_tmr_fault_manager
    import cv32e40p_tmr_pkg::*;
#(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned PERM_THRESH   = 8,
    parameter int unsigned RESYNC_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fault_valid_i,
    input  logic [NUM_REPLICAS-1:0]   mismatch_i,
    input  logic                      halt_ack_i,
    input  logic                      clear_i,
    output logic                      halt_req_o,
    output logic                      resync_o,
    output logic [NUM_REPLICAS-1:0]   resync_replica_o,
    output logic [NUM_REPLICAS-1:0]   replica_disabled_o,
    output logic                      fatal_o,
    output logic [3*CNT_W-1:0]        err_cnt_o
`ifdef CV32E40P_TMR_FAULT_LOG_EN
    ,
    output logic [31:0]               last_fault_cycle_o,
    output logic [NUM_REPLICAS-1:0]   last_fault_mask_o
`endif
);

    localparam int unsigned TIMER_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
    localparam int unsigned CMP_W   = CNT_W + 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESYNC_CYCLES - 1);
    localparam logic [CMP_W-1:0]   THRESH     = CMP_W'(PERM_THRESH);

    tmr_state_e                state_q, state_d;
    logic                      halt_q, halt_d;
    logic                      resync_q, resync_d;
    logic [NUM_REPLICAS-1:0]   rep_q, rep_d;
    logic [NUM_REPLICAS-1:0]   disabled_q, disabled_d;
    logic                      fatal_q, fatal_d;
    replica_idx_t              sel_q, sel_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;

    logic [NUM_REPLICAS-1:0]   masked;
    logic                      event_c;
    logic                      single_c;
    replica_idx_t              hit_idx;
    logic [CNT_W-1:0]          hit_cnt;
    logic                      thresh_hit;
    logic [NUM_REPLICAS-1:0]   cnt_inc;
    logic                      cnt_clr;
    logic [CNT_W-1:0]          cnt [NUM_REPLICAS];

    // Per-replica saturating error counters.
    for (genvar g = 0; g < NUM_REPLICAS; g++) begin : g_cnt
        cv32e40p_tmr_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[g]),
            .clr   (cnt_clr),
            .value (cnt[g])
        );
        assign err_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Event classification with retired replicas masked out.
    always_comb begin
        masked   = mismatch_i & ~disabled_q;
        event_c  = fault_valid_i && (masked != '0);
        single_c = (count_ones(masked) == 2'd1);
        hit_idx  = '0;
        hit_cnt  = '0;
        for (int unsigned i = 0; i < NUM_REPLICAS; i++) begin
            if (masked[i]) begin
                hit_idx = replica_idx_t'(i);
                hit_cnt = cnt[i];
            end
        end
        // Compare one bit wider so a saturated count cannot wrap below the threshold.
        thresh_hit = (CMP_W'(hit_cnt) + CMP_W'(1)) >= THRESH;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        resync_d   = resync_q;
        rep_d      = rep_q;
        disabled_d = disabled_q;
        fatal_d    = fatal_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        cnt_inc    = '0;
        cnt_clr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (event_c) begin
                    if (!single_c) begin
                        state_d = FATAL;
                        fatal_d = 1'b1;
                        halt_d  = 1'b1;
                    end else begin
                        cnt_inc = masked;
                        if (thresh_hit) begin
                            // Retire the replica instead of resyncing it.
                            disabled_d = disabled_q | masked;
                            if (count_ones(~disabled_d) < 2'd2) begin
                                state_d = FATAL;
                                fatal_d = 1'b1;
                                halt_d  = 1'b1;
                            end
                        end else begin
                            sel_d   = hit_idx;
                            state_d = HALT;
                            halt_d  = 1'b1;
                        end
                    end
                end else if (clear_i) begin
                    cnt_clr    = 1'b1;
                    disabled_d = '0;
                end
            end
            HALT: begin
                halt_d = 1'b1;
                if (halt_ack_i) begin
                    state_d  = RESYNC;
                    timer_d  = TIMER_LOAD;
                    resync_d = 1'b1;
                    rep_d    = onehot(sel_q);
                end
            end
            RESYNC: begin
                if (timer_q == '0) begin
                    state_d  = IDLE;
                    halt_d   = 1'b0;
                    resync_d = 1'b0;
                    rep_d    = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            FATAL: begin
                fatal_d = 1'b1;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            halt_q     <= 1'b0;
            resync_q   <= 1'b0;
            rep_q      <= '0;
            disabled_q <= '0;
            fatal_q    <= 1'b0;
            sel_q      <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            resync_q   <= resync_d;
            rep_q      <= rep_d;
            disabled_q <= disabled_d;
            fatal_q    <= fatal_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
        end
    end

    assign halt_req_o         = halt_q;
    assign resync_o           = resync_q;
    assign resync_replica_o   = rep_q;
    assign replica_disabled_o = disabled_q;
    assign fatal_o            = fatal_q;

`ifdef CV32E40P_TMR_FAULT_LOG_EN
    logic [31:0] cycle_q;

    // Timestamp every raw mismatch, whatever the state or mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q            <= '0;
            last_fault_cycle_o <= '0;
            last_fault_mask_o  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (fault_valid_i && (mismatch_i != '0)) begin
                last_fault_cycle_o <= cycle_q;
                last_fault_mask_o  <= mismatch_i;
            end
        end
    end
`else
    // Fault logging not built: no timestamp counter or log outputs.
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Self-checking bench for cv32e40p_tmr_fault_manager (default parameters).
module tb_cv32e40p_tmr_fault_manager;

    logic        clk;
    logic        rst_n;
    logic        fv;
    logic [2:0]  mm;
    logic        ack;
    logic        clr;
    logic        halt;
    logic        resync;
    logic [2:0]  rep;
    logic [2:0]  dis;
    logic        fatal;
    logic [11:0] err_cnt;
`ifdef CV32E40P_TMR_FAULT_LOG_EN
    logic [31:0] log_cycle;
    logic [2:0]  log_mask;
`endif

    int n_checks;
    int n_pass;

    cv32e40p_tmr_fault_manager dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fault_valid_i      (fv),
        .mismatch_i         (mm),
        .halt_ack_i         (ack),
        .clear_i            (clr),
        .halt_req_o         (halt),
        .resync_o           (resync),
        .resync_replica_o   (rep),
        .replica_disabled_o (dis),
        .fatal_o            (fatal),
        .err_cnt_o          (err_cnt)
`ifdef CV32E40P_TMR_FAULT_LOG_EN
        ,
        .last_fault_cycle_o (log_cycle),
        .last_fault_mask_o  (log_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [2:0]  mm;
        logic        clr;
        logic        halt;
        logic        fatal;
        logic [11:0] cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fv    = 1'b0;
        mm    = 3'b000;
        ack   = 1'b0;
        clr   = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // One full correctable recovery on replica oh, checking the count afterwards.
    task automatic recover(input logic [2:0] oh, input logic [11:0] exp_cnt);
        int n;
        fv = 1'b1;
        mm = oh;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("rec_halt", 32'(halt), 32'd1);
        chk("rec_cnt", 32'(err_cnt), 32'(exp_cnt));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rec_resync_on", 32'(resync), 32'd1);
        chk("rec_rep", 32'(rep), 32'(oh));
        n = 1;
        for (int c = 0; c < 40 && resync; c++) begin
            step();
            if (resync) n++;
        end
        chk("rec_resync_len", 32'(n), 32'd16);
        chk("rec_halt_drop", 32'(halt), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        fv       = 1'b0;
        mm       = 3'b000;
        ack      = 1'b0;
        clr      = 1'b0;

        //                fv    mm      clr   halt  fatal cnt
        vecs[0] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[1] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[2] = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 12'h001};
        vecs[3] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 12'h010};
        vecs[4] = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 12'h100};
        vecs[5] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[6] = '{1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[7] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[8] = '{1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 12'h001};

        // Reset then 100 idle cycles.
        step();
        #1;
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_fatal", 32'(fatal), 32'd0);
        rst_n = 1'b1;
        begin
            logic any_out;
            any_out = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                any_out = any_out | halt | resync | fatal | (|rep) | (|dis) | (|err_cnt);
            end
            chk("idle_any_output", 32'(any_out), 32'd0);
            chk("idle_cnt", 32'(err_cnt), 32'd0);
            chk("idle_dis", 32'(dis), 32'd0);
        end

        // Single-cycle classification from a fresh IDLE.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            fv  = vecs[i].fv;
            mm  = vecs[i].mm;
            clr = vecs[i].clr;
            step();
            fv  = 1'b0;
            mm  = 3'b000;
            clr = 1'b0;
            chk($sformatf("vec%0d_halt", i), 32'(halt), 32'(vecs[i].halt));
            chk($sformatf("vec%0d_fatal", i), 32'(fatal), 32'(vecs[i].fatal));
            chk($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_resync", i), 32'(resync), 32'd0);
        end

        // Recovery on replica 1 with mismatches ignored in HALT and RESYNC, then clear.
        do_reset();
        fv = 1'b1;
        mm = 3'b010;
        step();
        chk("t2_halt", 32'(halt), 32'd1);
        chk("t2_cnt", 32'(err_cnt), 32'h010);
        chk("t2_resync_early", 32'(resync), 32'd0);
        mm = 3'b001;
        step();
        fv = 1'b0;
        mm = 3'b000;
        step();
        chk("t2_halt_wait", 32'(halt), 32'd1);
        chk("t2_cnt_halt_ign", 32'(err_cnt), 32'h010);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_resync_on", 32'(resync), 32'd1);
        chk("t2_rep", 32'(rep), 32'b010);
        begin
            int n;
            n = 1;
            for (int c = 0; c < 40 && resync; c++) begin
                fv = (c == 4);
                mm = (c == 4) ? 3'b111 : 3'b000;
                chk("t2_halt_in_resync", 32'(halt), 32'd1);
                step();
                if (resync) n++;
            end
            fv = 1'b0;
            mm = 3'b000;
            chk("t2_resync_len", 32'(n), 32'd16);
        end
        chk("t2_halt_drop", 32'(halt), 32'd0);
        chk("t2_rep_drop", 32'(rep), 32'd0);
        chk("t2_cnt_after", 32'(err_cnt), 32'h010);
        chk("t2_fatal", 32'(fatal), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t2_clear", 32'(err_cnt), 32'd0);

        // Uncorrectable -> sticky fatal.
        do_reset();
        fv = 1'b1;
        mm = 3'b011;
        step();
        chk("t3_fatal", 32'(fatal), 32'd1);
        chk("t3_halt", 32'(halt), 32'd1);
        mm  = 3'b001;
        clr = 1'b1;
        repeat (5) step();
        fv  = 1'b0;
        mm  = 3'b000;
        clr = 1'b0;
        chk("t3_fatal_sticky", 32'(fatal), 32'd1);
        chk("t3_halt_sticky", 32'(halt), 32'd1);
        chk("t3_cnt", 32'(err_cnt), 32'd0);
        chk("t3_resync", 32'(resync), 32'd0);
        do_reset();
        chk("t3_fatal_reset", 32'(fatal), 32'd0);

        // Permanent retirement of replica 2, then replica 0 -> fatal.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            recover(3'b100, 12'(i) << 8);
        end
        fv = 1'b1;
        mm = 3'b100;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("t4_dis2", 32'(dis), 32'b100);
        chk("t4_cnt2", 32'(err_cnt), 32'h800);
        chk("t4_no_halt", 32'(halt), 32'd0);
        step();
        chk("t4_no_halt2", 32'(halt), 32'd0);
        chk("t4_no_resync", 32'(resync), 32'd0);
        fv = 1'b1;
        mm = 3'b100;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("t4_masked_halt", 32'(halt), 32'd0);
        chk("t4_masked_cnt", 32'(err_cnt), 32'h800);
        for (int i = 1; i <= 7; i++) begin
            recover(3'b001, 12'h800 | 12'(i));
        end
        fv = 1'b1;
        mm = 3'b001;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("t4_dis_both", 32'(dis), 32'b101);
        chk("t4_fatal", 32'(fatal), 32'd1);
        chk("t4_fatal_halt", 32'(halt), 32'd1);
        chk("t4_cnt_final", 32'(err_cnt), 32'h808);

        // Asynchronous reset in the 5th RESYNC cycle.
        do_reset();
        fv = 1'b1;
        mm = 3'b001;
        step();
        fv  = 1'b0;
        mm  = 3'b000;
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (4) step();
        chk("t5_in_resync", 32'(resync), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_resync_async", 32'(resync), 32'd0);
        chk("t5_halt_async", 32'(halt), 32'd0);
        chk("t5_rep_async", 32'(rep), 32'd0);
        chk("t5_cnt_async", 32'(err_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t5_idle_after", 32'(halt), 32'd0);

`ifdef CV32E40P_TMR_FAULT_LOG_EN
        // Timestamp log: event on cycle 1000, then an ignored event during RESYNC.
        do_reset();
        repeat (1000) step();
        fv = 1'b1;
        mm = 3'b001;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("t6_log_cycle", log_cycle, 32'd1000);
        chk("t6_log_mask", 32'(log_mask), 32'b001);
        ack = 1'b1;
        step();
        ack = 1'b0;
        fv = 1'b1;
        mm = 3'b110;
        step();
        fv = 1'b0;
        mm = 3'b000;
        chk("t6_log_cycle_resync", log_cycle, 32'd1002);
        chk("t6_log_mask_resync", 32'(log_mask), 32'b110);
        chk("t6_cnt_unchanged", 32'(err_cnt), 32'h001);
        for (int c = 0; c < 40 && resync; c++) step();
        chk("t6_resync_done", 32'(resync), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
